// File: rtl/apb_uart_fifo.sv
// apb_uart_fifo: APB-attached UART with TX/RX FIFOs, sticky error flags and a level interrupt.
module apb_uart_fifo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BIT_RATE   = 9600,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_EN  = 0
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       PSEL,
    input  logic       PENABLE,
    input  logic       PWRITE,
    input  logic [7:0] PADDR,
    input  logic [7:0] PWDATA,
    output logic [7:0] PRDATA,
    output logic       PREADY,
    output logic       PSLVERR,
    input  logic       rxd,
    output logic       txd,
    output logic       irq
);
    localparam int DIV = CLK_HZ / BIT_RATE;
    localparam int CW = $clog2(DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_END = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_END = CW'(DIV / 2 - 1);
    localparam logic [2:0] LAST = 3'(DATA_W - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    logic [5:0] ctrl;
    logic ovr, fe, pe;
    logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic acc, wr, rd, a_data, a_stat, a_ctrl;
    logic tx_pop, tx_push, rx_pop, rx_push, rx_tick, rx_done;
    logic ovr_set, fe_set, pe_set, w1c;
    state_t tx_st, rx_st;
    logic [CW-1:0] tx_cnt, rx_cnt;
    logic [2:0] tx_bit, rx_bit;
    logic [DATA_W-1:0] tx_sh, rx_sh;
    logic tx_par, rx_p, s1, s2, s_prev;
    logic [7:0] status;

    assign tx_empty = tx_wp == tx_rp;
    assign rx_empty = rx_wp == rx_rp;
    assign tx_full = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
    assign rx_full = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
    assign acc = PSEL && PENABLE;
    assign wr = acc && PWRITE;
    assign rd = acc && !PWRITE;
    assign a_data = PADDR == 8'h00;
    assign a_stat = PADDR == 8'h04;
    assign a_ctrl = PADDR == 8'h08;
    assign PREADY = acc;

    // A pop by the transmitter in the same cycle frees the slot a full-FIFO write needs.
    assign tx_pop = ctrl[0] && !tx_empty && (tx_st == IDLE || (tx_st == STOP && tx_cnt == BIT_END));
    assign tx_push = wr && a_data && (!tx_full || tx_pop);
    assign rx_pop = rd && a_data && !rx_empty;
    assign rx_tick = rx_cnt == BIT_END;
    assign rx_done = rx_st == STOP && rx_tick;
    assign rx_push = rx_done && (!rx_full || rx_pop);
    assign ovr_set = rx_done && rx_full && !rx_pop;
    assign fe_set = rx_done && !s2;
    assign pe_set = rx_done && (PARITY_EN != 0) && (rx_p != (^rx_sh ^ ctrl[2]));
    assign w1c = wr && a_stat;

    assign status = {tx_st != IDLE, pe, fe, ovr, rx_empty, rx_full, tx_empty, tx_full};
    assign PRDATA = !rd ? 8'h00 :
                    a_data ? (rx_empty ? 8'h00 : 8'(rx_mem[rx_rp[AW-1:0]])) :
                    a_stat ? status :
                    a_ctrl ? {2'b00, ctrl} : 8'h00;
    assign PSLVERR = !PRESET && acc && (!(a_data || a_stat || a_ctrl) ||
                     (wr && a_data && tx_full && !tx_pop) || (rd && a_data && rx_empty));
    assign irq = (ctrl[3] && !rx_empty) || (ctrl[4] && tx_empty) || (ctrl[5] && (ovr || fe || pe));

    always_ff @(posedge PCLK) begin
        if (tx_push) tx_mem[tx_wp[AW-1:0]] <= PWDATA[DATA_W-1:0];
        if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_wp <= '0;
            tx_rp <= '0;
            rx_wp <= '0;
            rx_rp <= '0;
            ctrl <= 6'h03;
            ovr <= 1'b0;
            fe <= 1'b0;
            pe <= 1'b0;
        end else begin
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop) tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop) rx_rp <= rx_rp + 1'b1;
            if (wr && a_ctrl) ctrl <= PWDATA[5:0];
            ovr <= ovr_set || (ovr && !(w1c && PWDATA[4]));
            fe <= fe_set || (fe && !(w1c && PWDATA[5]));
            pe <= pe_set || (pe && !(w1c && PWDATA[6]));
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tx_st <= IDLE;
            txd <= 1'b1;
            tx_cnt <= '0;
            tx_bit <= '0;
            tx_sh <= '0;
            tx_par <= 1'b0;
        end else if (tx_pop) begin
            tx_st <= START;
            txd <= 1'b0;
            tx_cnt <= '0;
            tx_sh <= tx_mem[tx_rp[AW-1:0]];
        end else if (tx_st != IDLE) begin
            tx_cnt <= (tx_cnt == BIT_END) ? '0 : tx_cnt + 1'b1;
            if (tx_cnt == BIT_END) begin
                case (tx_st)
                    START: begin
                        tx_st <= DATA;
                        txd <= tx_sh[0];
                        tx_sh <= tx_sh >> 1;
                        tx_bit <= '0;
                        tx_par <= ^tx_sh ^ ctrl[2];
                    end
                    DATA: begin
                        if (tx_bit == LAST) begin
                            tx_st <= (PARITY_EN != 0) ? PAR : STOP;
                            txd <= (PARITY_EN != 0) ? tx_par : 1'b1;
                        end else begin
                            tx_bit <= tx_bit + 1'b1;
                            txd <= tx_sh[0];
                            tx_sh <= tx_sh >> 1;
                        end
                    end
                    PAR: begin
                        tx_st <= STOP;
                        txd <= 1'b1;
                    end
                    default: begin
                        tx_st <= IDLE;
                        txd <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Synchroniser resets high so a frame cut by reset needs a fresh falling edge.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s_prev <= 1'b1;
            rx_st <= IDLE;
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_sh <= '0;
            rx_p <= 1'b0;
        end else begin
            s1 <= rxd;
            s2 <= s1;
            s_prev <= s2;
            case (rx_st)
                IDLE: begin
                    if (ctrl[1] && s_prev && !s2) begin
                        rx_st <= START;
                        rx_cnt <= '0;
                    end
                end
                START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_st <= s2 ? IDLE : DATA;
                        rx_cnt <= '0;
                        rx_bit <= '0;
                    end else rx_cnt <= rx_cnt + 1'b1;
                end
                default: begin
                    rx_cnt <= rx_tick ? '0 : rx_cnt + 1'b1;
                    if (rx_tick) begin
                        if (rx_st == DATA) begin
                            rx_sh <= {s2, rx_sh[DATA_W-1:1]};
                            rx_bit <= rx_bit + 1'b1;
                            if (rx_bit == LAST) rx_st <= (PARITY_EN != 0) ? PAR : STOP;
                        end else if (rx_st == PAR) begin
                            rx_p <= s2;
                            rx_st <= STOP;
                        end else rx_st <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/apb_uart_fifo.md
APB_UART_FIFO -- requirements
Module: apb_uart_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, meaning the PCLK frequency in Hz.
REQ-002 SHALL have parameter BIT_RATE, default 9600, meaning the serial bit rate; bit period DIV = CLK_HZ/BIT_RATE cycles (integer divide, DIV >= 4).
REQ-003 SHALL have parameter DATA_W, default 8, meaning the serial data bits per frame; legal range 5..8.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning the entries per TX and RX FIFO; power of 2, >= 2.
REQ-005 SHALL have parameter PARITY_EN, default 0, meaning one parity bit after the data bits when 1.
REQ-006 PCLK  input  1  the single clock; all logic is on the rising edge.
REQ-007 PRESET  input  1  asynchronous, active-high reset.
REQ-008 PSEL, PENABLE, PWRITE  input  1 each  APB control.
REQ-009 PADDR  input  8  register address.
REQ-010 PWDATA  input  8  write data.
REQ-011 PRDATA  output  8  read data.
REQ-012 PREADY  output  1  transfer complete.
REQ-013 PSLVERR  output  1  transfer error.
REQ-014 rxd  input  1  serial in; asynchronous to PCLK.
REQ-015 txd  output  1  serial out.
REQ-016 irq  output  1  level interrupt.

Function
REQ-017 The access phase SHALL be PSEL&PENABLE; PREADY SHALL equal PSEL&PENABLE (zero wait states).
REQ-018 PRDATA SHALL be combinational, valid in read access phases, and 0 otherwise.
REQ-019 Register map:
- 0x00 DATA: a write pushes PWDATA[DATA_W-1:0] into the TX FIFO; a read pops the RX FIFO, zero-extended.
- 0x04 STATUS (RO except W1C bits):
  - bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty
  - bit4 overrun, bit5 framing_err, bit6 parity_err (sticky, write-1-to-clear)
  - bit7 tx_busy
- 0x08 CTRL (RW): bit0 tx_en, bit1 rx_en, bit2 parity_odd, bit3 ie_rx, bit4 ie_tx, bit5 ie_err.
REQ-020 PSLVERR SHALL be 1 in the access phase for:
- an unmapped address (reads return 0, writes have no effect);
- a DATA write with the TX FIFO full (data dropped);
- a DATA read with the RX FIFO empty (PRDATA=0, no pop).
REQ-021 FIFO push/pop SHALL take effect at the PCLK edge ending the access phase; the status flags SHALL reflect the new state on the next cycle.
REQ-022 Simultaneous push and pop on a full FIFO SHALL both succeed, with no drop and no overrun. On an empty FIFO the pop SHALL fail and the push SHALL succeed.
REQ-023 TX FSM IDLE->START->DATA->(PARITY)->STOP->IDLE, with each state lasting DIV cycles per bit.
- In IDLE, with tx_en=1 and the TX FIFO non-empty, the FSM SHALL pop one entry and enter START on the same edge.
- txd: START=0, DATA LSB-first, PARITY=even (odd if parity_odd), STOP=1, IDLE=1.
- After STOP, if the FIFO is non-empty the FSM SHALL start the next frame directly, with no idle gap.
REQ-024 Clearing tx_en mid-frame SHALL complete the current frame, then hold in IDLE.
REQ-025 rxd SHALL pass through a 2-flop synchroniser before use.
REQ-026 RX FSM IDLE->START->DATA->(PARITY)->STOP->IDLE, enabled by rx_en.
- START: entered on a synchronised 1->0 transition; after DIV/2 cycles, a low sample goes to DATA, a high sample goes back to IDLE (glitch rejected).
- Subsequent samples SHALL be taken every DIV cycles, at mid-bit.
REQ-027 At STOP sample:
- the byte SHALL be pushed to the RX FIFO;
- a stop sample of 0 SHALL set framing_err;
- a parity mismatch SHALL set parity_err.
- If the RX FIFO is full and no pop occurs that cycle, the byte SHALL be dropped and overrun set.
REQ-028 irq SHALL equal (ie_rx&!rx_empty) | (ie_tx&tx_empty) | (ie_err&(overrun|framing_err|parity_err)).
REQ-029 A W1C write and a same-cycle error set SHALL leave the bit set.

Reset
REQ-030 PRESET=1 SHALL immediately:
- force txd=1, irq=0, PSLVERR=0;
- empty both FIFOs and clear the sticky bits;
- set CTRL=0x03 and return both FSMs to IDLE.
REQ-031 Reset asserted mid-frame SHALL abort the frame; after release, RX SHALL wait for a new falling edge.

Verification (CLK_HZ=1_000_000, BIT_RATE=100_000 -> DIV=10; DATA_W=8; FIFO_DEPTH=4)
REQ-032 Write 0x00<=0xA5 -> txd low for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then stop=1; tx_busy returns to 0 after 100 cycles.
REQ-033 Drive a 0x3C frame on rxd -> STATUS.rx_empty=0, irq=1 with ie_rx=1, read 0x00 returns 0x3C, then rx_empty=1.
REQ-034 Receive 5 frames without reading -> first 4 are read back in order, overrun=1; write STATUS 0x10 -> overrun=0.
REQ-035 Five DATA writes back-to-back with tx_en=0 -> 5th write gets PSLVERR=1; set tx_en -> 4 frames sent with no gap.
REQ-036 PARITY_EN=1, parity_odd=0, receive 0x01 with parity bit 0 -> parity_err=1; 3-cycle low glitch on rxd -> no frame received.
REQ-037 Assert PRESET mid-TX-frame -> txd=1 the same cycle, STATUS=0x0A, CTRL=0x03.
